// File: rtl/dabus_pkg.sv
// Shared definitions for the SRIO 64-bit data bus byte-lane packer.
// Lane k occupies data bits [8k+7:8k]; byte-enable bit (7-k) qualifies lane k.
package dabus_pkg;

    localparam int LANES = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PACK  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // Lane index of the first enabled byte, scanning be[7] downward; all-zero gives 0.
    function automatic logic [2:0] lead_offset(input logic [7:0] be);
        logic [2:0] o;
        logic       found;
        o     = 3'd0;
        found = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (!found && be[LANES-1-i]) begin
                o     = 3'(i);
                found = 1'b1;
            end
        end
        return o;
    endfunction

    // Byte enables covering lanes 0..n-1.
    function automatic logic [7:0] be_from_count(input logic [3:0] n);
        logic [7:0] b;
        b = '0;
        for (int i = 0; i < LANES; i++) begin
            b[LANES-1-i] = (i < int'(n));
        end
        return b;
    endfunction

    // Number of enabled lanes.
    function automatic logic [3:0] popcount(input logic [7:0] be);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < LANES; i++) begin
            c = c + 4'(be[i]);
        end
        return c;
    endfunction

    // Expand byte enables into a bit mask over the data word.
    function automatic logic [LANES*8-1:0] lane_mask(input logic [7:0] be);
        logic [LANES*8-1:0] m;
        m = '0;
        for (int k = 0; k < LANES; k++) begin
            m[8*k +: 8] = {8{be[LANES-1-k]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/dabus_lane_shift.sv
// Combinational lane shifter: returns the low word of {i_hi, i_lo} shifted
// right by i_sh lanes (0..8). Used for leading-lane stripping and residue merge.
module dabus_lane_shift
    import dabus_pkg::*;
(
    input  logic [LANES*8-1:0] i_hi,
    input  logic [LANES*8-1:0] i_lo,
    input  logic [3:0]         i_sh,
    output logic [LANES*8-1:0] o_data
);

    assign o_data = (LANES*8)'({i_hi, i_lo} >> {i_sh, 3'b000});

endmodule

// File: rtl/dabus_pack_ctrl.sv
// Byte-lane realignment controller between the SRIO receive bus and the packet
// buffer. Strips leading empty lanes, carries residue across beats and emits
// densely packed words. Optional statistics counters: DABUS_PACK_STATS_EN.
module dabus_pack_ctrl
    import dabus_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic [7:0]        s_be,
    input  logic              s_sof,
    input  logic              s_eof,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [7:0]        m_be,
    output logic              m_eof,
    output logic              err,
    output logic [CNT_W-1:0]  pkt_cnt,
    output logic [CNT_W-1:0]  byte_cnt
);

    state_t             r_state, w_state_nxt;
    logic               r_m_valid, r_m_eof, r_err, r_rdy_en;
    logic [DATA_W-1:0]  r_m_data, r_res;
    logic [7:0]         r_m_be;
    logic [3:0]         r_r, w_r_nxt, r_left, w_left_nxt;

    logic               w_m_free, w_s_ready, w_beat;
    logic [2:0]         w_o;
    logic [3:0]         w_n, w_sh_cnt, w_mrg_cnt;
    logic [4:0]         w_t;
    logic [DATA_W-1:0]  w_sh_src, w_sh_out, w_mrg_out, w_word_data;
    logic [7:0]         w_word_be;
    logic               w_load, w_res_load, w_err_nxt, w_word_eof;

    assign w_o       = lead_offset(s_be);
    assign w_n       = popcount(s_be);
    assign w_t       = {1'b0, r_r} + {1'b0, w_n};
    assign w_mrg_cnt = 4'(LANES) - r_r;
    assign w_m_free  = !r_m_valid || m_ready;
    assign w_s_ready = r_rdy_en && (r_state != FLUSH) && w_m_free;
    assign w_beat    = s_valid && w_s_ready;

    // The strip shifter is idle during FLUSH (no input accepted), so it is
    // reused there to bring the held leftover bytes down to lane 0.
    assign w_sh_src  = (r_state == FLUSH) ? r_res : s_data;
    assign w_sh_cnt  = (r_state == FLUSH) ? w_mrg_cnt : {1'b0, w_o};

    dabus_lane_shift u_sof_shift (
        .i_hi   ({DATA_W{1'b0}}),
        .i_lo   (w_sh_src),
        .i_sh   (w_sh_cnt),
        .o_data (w_sh_out)
    );

    // Residue lives in the top r lanes of the previous raw beat, so shifting
    // {beat, previous} right by 8-r lanes yields {low 8-r input lanes, residue}.
    dabus_lane_shift u_merge (
        .i_hi   (s_data),
        .i_lo   (r_res),
        .i_sh   (w_mrg_cnt),
        .o_data (w_mrg_out)
    );

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, next output word and residue bookkeeping.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_word_data = '0;
        w_word_be   = '0;
        w_word_eof  = 1'b0;
        w_err_nxt   = 1'b0;
        w_r_nxt     = r_r;
        w_left_nxt  = r_left;
        w_res_load  = 1'b0;
        case (r_state)
            IDLE, PACK: begin
                if (w_beat) begin
                    if (s_sof) begin
                        // A new SOF while packing abandons the current residue.
                        w_err_nxt = (r_state == PACK);
                        if (s_eof) begin
                            w_load      = 1'b1;
                            w_word_be   = be_from_count(w_n);
                            w_word_data = w_sh_out & lane_mask(w_word_be);
                            w_word_eof  = 1'b1;
                            w_r_nxt     = 4'd0;
                            w_state_nxt = IDLE;
                        end else begin
                            w_res_load  = 1'b1;
                            w_state_nxt = PACK;
                            w_r_nxt     = 4'(LANES) - {1'b0, w_o};
                            if (w_o == 3'd0) begin
                                w_load      = 1'b1;
                                w_word_be   = 8'hFF;
                                w_word_data = s_data;
                                w_r_nxt     = 4'd0;
                            end
                        end
                    end else if (r_state == IDLE) begin
                        w_err_nxt = 1'b1;
                    end else if (!s_eof) begin
                        w_load      = 1'b1;
                        w_word_be   = 8'hFF;
                        w_word_data = w_mrg_out;
                        w_res_load  = 1'b1;
                    end else if (w_t <= 5'd8) begin
                        w_load      = 1'b1;
                        w_word_be   = be_from_count(w_t[3:0]);
                        w_word_data = w_mrg_out & lane_mask(w_word_be);
                        w_word_eof  = 1'b1;
                        w_r_nxt     = 4'd0;
                        w_state_nxt = IDLE;
                    end else begin
                        w_load      = 1'b1;
                        w_word_be   = 8'hFF;
                        w_word_data = w_mrg_out;
                        w_res_load  = 1'b1;
                        w_left_nxt  = 4'(w_t - 5'd8);
                        w_state_nxt = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (w_m_free) begin
                    w_load      = 1'b1;
                    w_word_be   = be_from_count(r_left);
                    w_word_data = w_sh_out & lane_mask(w_word_be);
                    w_word_eof  = 1'b1;
                    w_r_nxt     = 4'd0;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output register, residue storage and error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_be    <= '0;
            r_m_eof   <= 1'b0;
            r_err     <= 1'b0;
            r_rdy_en  <= 1'b0;
            r_r       <= '0;
            r_left    <= '0;
            // NOTE: residue data is reset too; one register, and it keeps reset state deterministic.
            r_res     <= '0;
        end else begin
            r_rdy_en <= 1'b1;
            r_err    <= w_err_nxt;
            r_r      <= w_r_nxt;
            r_left   <= w_left_nxt;
            if (w_res_load) begin
                r_res <= s_data;
            end
            if (w_load) begin
                r_m_valid <= 1'b1;
                r_m_data  <= w_word_data;
                r_m_be    <= w_word_be;
                r_m_eof   <= w_word_eof;
            end else if (m_ready) begin
                r_m_valid <= 1'b0;
            end
        end
    end

    assign s_ready = w_s_ready;
    assign m_valid = r_m_valid;
    assign m_data  = r_m_data;
    assign m_be    = r_m_be;
    assign m_eof   = r_m_eof;
    assign err     = r_err;

`ifdef DABUS_PACK_STATS_EN
    logic [CNT_W-1:0] r_pkt_cnt, r_byte_cnt;

    // Count accepted packets and emitted bytes; both wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pkt_cnt  <= '0;
            r_byte_cnt <= '0;
        end else if (r_m_valid && m_ready) begin
            if (r_m_eof) begin
                r_pkt_cnt <= r_pkt_cnt + CNT_W'(1);
            end
            r_byte_cnt <= r_byte_cnt + CNT_W'(popcount(r_m_be));
        end
    end

    assign pkt_cnt  = r_pkt_cnt;
    assign byte_cnt = r_byte_cnt;
`else
    assign pkt_cnt  = '0;
    assign byte_cnt = '0;
`endif

endmodule

// File: tb/tb_dabus_pack_ctrl.sv
// Scoreboard bench for dabus_pack_ctrl: a byte-stream model builds expected
// packed words; a monitor records accepted output words for comparison.
module tb_dabus_pack_ctrl;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  be;
        logic        eof;
    } word_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_valid, s_sof, s_eof;
    logic [63:0] s_data;
    logic [7:0]  s_be;
    logic        m_ready = 1'b0;
    logic        s_ready, m_valid, m_eof, err;
    logic [63:0] m_data;
    logic [7:0]  m_be;
    logic [15:0] pkt_cnt, byte_cnt;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          err_cycles = 0;
    int          stable_viol = 0;
    bit          timed_out = 1'b0;
    bit          bp_en = 1'b0;
    logic        mr_level = 1'b1;

    logic [7:0]  model_bytes[$];
    word_t       exp_q[$];
    word_t       obs_q[$];

    dabus_pack_ctrl #(.DATA_W(64), .CNT_W(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .s_be     (s_be),
        .s_sof    (s_sof),
        .s_eof    (s_eof),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_be     (m_be),
        .m_eof    (m_eof),
        .err      (err),
        .pkt_cnt  (pkt_cnt),
        .byte_cnt (byte_cnt)
    );

    always #5 clk = ~clk;

    // Downstream ready: fixed level, or alternating every cycle when bp_en.
    always @(posedge clk) begin
        #1;
        if (bp_en) m_ready = ~m_ready;
        else       m_ready = mr_level;
    end

    // Monitor: record accepted words, error cycles and stall stability.
    word_t prev_w;
    logic  prev_stall = 1'b0;
    always @(negedge clk) begin
        word_t cur;
        cur.d = m_data; cur.be = m_be; cur.eof = m_eof;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (!m_valid || cur !== prev_w)) stable_viol++;
            if (m_valid && m_ready) obs_q.push_back(cur);
            if (err) err_cycles++;
            prev_stall = m_valid && !m_ready;
            prev_w     = cur;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [63:0] mk(input logic [7:0] base);
        logic [63:0] d;
        for (int k = 0; k < 8; k++) d[8*k +: 8] = base + 8'(k);
        return d;
    endfunction

    // Model: append enabled bytes in lane order.
    task automatic model_beat(input logic [63:0] d, input logic [7:0] be);
        for (int k = 0; k < 8; k++) if (be[7-k]) model_bytes.push_back(d[8*k +: 8]);
    endtask

    // Model: packet end, pack all bytes, eof on the last word.
    task automatic model_eof();
        word_t w;
        while (model_bytes.size() > 0) begin
            w = '0;
            for (int k = 0; k < 8 && model_bytes.size() > 0; k++) begin
                w.d[8*k +: 8] = model_bytes.pop_front();
                w.be[7-k]     = 1'b1;
            end
            w.eof = (model_bytes.size() == 0);
            exp_q.push_back(w);
        end
    endtask

    // Model: packet abandoned, only already-complete words survive.
    task automatic model_abort();
        word_t w;
        while (model_bytes.size() >= 8) begin
            w = '0;
            for (int k = 0; k < 8; k++) begin
                w.d[8*k +: 8] = model_bytes.pop_front();
                w.be[7-k]     = 1'b1;
            end
            exp_q.push_back(w);
        end
        model_bytes.delete();
    endtask

    // Drive one beat until accepted; returns 1 time unit after the accepting edge.
    task automatic send_beat(input logic [63:0] d, input logic [7:0] be,
                             input logic sof, input logic eof, input logic keep);
        int n;
        n = 0;
        s_valid = 1'b1; s_data = d; s_be = be; s_sof = sof; s_eof = eof;
        if (keep) model_beat(d, be);
        forever begin
            @(negedge clk);
            if (s_ready) break;
            n++;
            if (n > 200) begin timed_out = 1'b1; break; end
        end
        @(posedge clk); #1;
        s_valid = 1'b0; s_sof = 1'b0; s_eof = 1'b0;
    endtask

    // Wait (bounded) for all expected words plus a few idle cycles.
    task automatic wait_drain();
        int n;
        n = 0;
        repeat (4) @(negedge clk);
        while (obs_q.size() < exp_q.size() && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (obs_q.size() < exp_q.size()) timed_out = 1'b1;
        repeat (4) @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk); #1;
        n_checks++;
        if ({m_valid, m_eof, err, s_ready} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ctrl: valid/eof/err/ready=%b expected 0000", {m_valid, m_eof, err, s_ready});
        end
        n_checks++;
        if (m_data !== 64'h0 || m_be !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_data: m_data=%h m_be=%h expected 0 0", m_data, m_be);
        end
        n_checks++;
        if (pkt_cnt !== 16'h0 || byte_cnt !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_cnt: pkt=%0d byte=%0d expected 0 0", pkt_cnt, byte_cnt);
        end
        rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;
        n_checks++;
        if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset: s_ready=%b m_valid=%b expected 1 0", s_ready, m_valid);
        end
    endtask

    task automatic test_aligned();
        word_t e, o;
        logic [63:0] d0;
        timed_out = 1'b0; bp_en = 1'b0; mr_level = 1'b1;
        repeat (2) @(posedge clk); #1;
        d0 = mk(8'h00);
        send_beat(d0, 8'hFF, 1'b1, 1'b0, 1'b1);
        n_checks++;
        if (m_valid !== 1'b1 || m_data !== d0 || m_be !== 8'hFF || m_eof !== 1'b0) begin
            n_fail++;
            $display("FAIL aligned_latency: valid=%b data=%h be=%h eof=%b expected 1 %h ff 0", m_valid, m_data, m_be, m_eof, d0);
        end
        send_beat(mk(8'h08), 8'hFF, 1'b0, 1'b0, 1'b1);
        send_beat(mk(8'h10), 8'hFF, 1'b0, 1'b0, 1'b1);
        send_beat(mk(8'h18), 8'hFF, 1'b0, 1'b1, 1'b1);
        model_eof();
        wait_drain();
        n_checks++;
        if (timed_out || obs_q.size() != exp_q.size() || exp_q.size() != 4) begin
            n_fail++;
            $display("FAIL aligned_count: got %0d words expected %0d (timeout=%0b)", obs_q.size(), exp_q.size(), timed_out);
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL aligned_word: got %h/%h/%b expected %h/%h/%b", o.d, o.be, o.eof, e.d, e.be, e.eof);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_flush();
        word_t e, o;
        timed_out = 1'b0; bp_en = 1'b0; mr_level = 1'b1;
        repeat (2) @(posedge clk); #1;
        send_beat(mk(8'h20), 8'h3F, 1'b1, 1'b0, 1'b1);
        send_beat(mk(8'h30), 8'hFF, 1'b0, 1'b0, 1'b1);
        send_beat(mk(8'h40), 8'hF0, 1'b0, 1'b1, 1'b1);
        n_checks++;
        if (s_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_ready: s_ready=%b expected 0 during flush", s_ready);
        end
        model_eof();
        wait_drain();
        n_checks++;
        if (timed_out || obs_q.size() != exp_q.size() || exp_q.size() != 3 || exp_q[2].be !== 8'hC0) begin
            n_fail++;
            $display("FAIL flush_count: got %0d words expected %0d (timeout=%0b)", obs_q.size(), exp_q.size(), timed_out);
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL flush_word: got %h/%h/%b expected %h/%h/%b", o.d, o.be, o.eof, e.d, e.be, e.eof);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_single();
        word_t e, o;
        timed_out = 1'b0; bp_en = 1'b0; mr_level = 1'b1;
        send_beat(mk(8'h50), 8'h3C, 1'b1, 1'b1, 1'b1);
        model_eof();
        wait_drain();
        n_checks++;
        if (timed_out || obs_q.size() != 1 || exp_q.size() != 1) begin
            n_fail++;
            $display("FAIL single_count: got %0d words expected 1 (timeout=%0b)", obs_q.size(), timed_out);
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL single_word: got %h/%h/%b expected %h/%h/%b", o.d, o.be, o.eof, e.d, e.be, e.eof);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_backpressure();
        word_t e, o;
        int viol0;
        timed_out = 1'b0; viol0 = stable_viol;
        bp_en = 1'b1;
        send_beat(mk(8'h60), 8'h1F, 1'b1, 1'b0, 1'b1);
        send_beat(mk(8'h68), 8'hFF, 1'b0, 1'b0, 1'b1);
        send_beat(mk(8'h70), 8'hFF, 1'b0, 1'b0, 1'b1);
        send_beat(mk(8'h78), 8'hFF, 1'b0, 1'b0, 1'b1);
        send_beat(mk(8'h80), 8'hFE, 1'b0, 1'b1, 1'b1);
        model_eof();
        wait_drain();
        bp_en = 1'b0; mr_level = 1'b1;
        n_checks++;
        if (stable_viol != viol0) begin
            n_fail++;
            $display("FAIL bp_stable: %0d payload changes while stalled, expected 0", stable_viol - viol0);
        end
        n_checks++;
        if (timed_out || obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL bp_count: got %0d words expected %0d (timeout=%0b)", obs_q.size(), exp_q.size(), timed_out);
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL bp_word: got %h/%h/%b expected %h/%h/%b", o.d, o.be, o.eof, e.d, e.be, e.eof);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_err_idle();
        int err0;
        timed_out = 1'b0; bp_en = 1'b0; mr_level = 1'b1;
        repeat (2) @(posedge clk); #1;
        err0 = err_cycles;
        send_beat(mk(8'h90), 8'hFF, 1'b0, 1'b0, 1'b0);
        wait_drain();
        n_checks++;
        if (err_cycles - err0 != 1) begin
            n_fail++;
            $display("FAIL err_idle_pulse: err high %0d cycles expected 1", err_cycles - err0);
        end
        n_checks++;
        if (timed_out || obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL err_idle_drop: got %0d words expected 0 (timeout=%0b)", obs_q.size(), timed_out);
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_sof_midpacket();
        word_t e, o;
        int err0;
        timed_out = 1'b0; bp_en = 1'b0; mr_level = 1'b1;
        err0 = err_cycles;
        send_beat(mk(8'hA0), 8'h0F, 1'b1, 1'b0, 1'b1);
        send_beat(mk(8'hA8), 8'hFF, 1'b0, 1'b0, 1'b1);
        model_abort();
        send_beat(mk(8'hB0), 8'hFF, 1'b1, 1'b0, 1'b1);
        send_beat(mk(8'hB8), 8'hFF, 1'b0, 1'b0, 1'b1);
        send_beat(mk(8'hC0), 8'hC0, 1'b0, 1'b1, 1'b1);
        model_eof();
        wait_drain();
        n_checks++;
        if (err_cycles - err0 != 1) begin
            n_fail++;
            $display("FAIL sof_mid_pulse: err high %0d cycles expected 1", err_cycles - err0);
        end
        n_checks++;
        if (timed_out || obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL sof_mid_count: got %0d words expected %0d (timeout=%0b)", obs_q.size(), exp_q.size(), timed_out);
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL sof_mid_word: got %h/%h/%b expected %h/%h/%b", o.d, o.be, o.eof, e.d, e.be, e.eof);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset_midpacket();
        word_t e, o;
        timed_out = 1'b0; bp_en = 1'b0; mr_level = 1'b1;
        send_beat(mk(8'hD0), 8'h3F, 1'b1, 1'b0, 1'b1);
        send_beat(mk(8'hD8), 8'hFF, 1'b0, 1'b0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({m_valid, m_eof, err, s_ready} !== 4'b0000 || m_data !== 64'h0 || m_be !== 8'h00) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: v/e/err/rdy=%b data=%h be=%h expected all 0", {m_valid, m_eof, err, s_ready}, m_data, m_be);
        end
        n_checks++;
        if (pkt_cnt !== 16'h0 || byte_cnt !== 16'h0) begin
            n_fail++;
            $display("FAIL rst_mid_cnt: pkt=%0d byte=%0d expected 0 0", pkt_cnt, byte_cnt);
        end
        model_bytes.delete(); exp_q.delete(); obs_q.delete();
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1;
        send_beat(mk(8'hE0), 8'hFF, 1'b1, 1'b0, 1'b1);
        send_beat(mk(8'hE8), 8'hF0, 1'b0, 1'b1, 1'b1);
        model_eof();
        wait_drain();
        n_checks++;
        if (timed_out || obs_q.size() != exp_q.size() || exp_q.size() != 2) begin
            n_fail++;
            $display("FAIL rst_mid_count: got %0d words expected %0d (timeout=%0b)", obs_q.size(), exp_q.size(), timed_out);
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL rst_mid_word: got %h/%h/%b expected %h/%h/%b", o.d, o.be, o.eof, e.d, e.be, e.eof);
            end
        end
        exp_q.delete(); obs_q.delete();
        n_checks++;
`ifdef DABUS_PACK_STATS_EN
        if (pkt_cnt !== 16'd1 || byte_cnt !== 16'd12) begin
            n_fail++;
            $display("FAIL rst_mid_stats: pkt=%0d byte=%0d expected 1 12", pkt_cnt, byte_cnt);
        end
`else
        if (pkt_cnt !== 16'd0 || byte_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL rst_mid_stats: pkt=%0d byte=%0d expected 0 0", pkt_cnt, byte_cnt);
        end
`endif
    endtask

    initial begin
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_sof   = 1'b0;
        s_eof   = 1'b0;
        s_data  = '0;
        s_be    = '0;
        test_reset();
        test_aligned();
        test_flush();
        test_single();
        test_backpressure();
        test_err_idle();
        test_sof_midpacket();
        test_reset_midpacket();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
